pma_seq_checker: RTL and testbench



---
 rtl/pma_seq_checker.sv | 191 +++++++++++++++++++
 tb/tb_pma_seq_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_seq_checker.sv
// Iterative PMA region checker: round-robin arbitrated queries, scanned RulesPerCycle rules per cycle.
// Optional build macro PMA_CHECK_EARLY_EXIT_EN leaves SCAN as soon as every attribute is already hit.

package pma_seq_checker_pkg;

  localparam int unsigned NrMaxRules = 8;

  typedef struct packed {
    int unsigned                     NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]     NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]     NonIdempotentLength;
    int unsigned                     NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]     ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]     ExecuteRegionLength;
    int unsigned                     NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]     CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]     CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

module pma_seq_checker
  import pma_seq_checker_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg       = cva6_cfg_empty,
  parameter int        NrRequesters  = 2,
  parameter int        RulesPerCycle = 1,
  localparam int       IdW           = (NrRequesters > 1) ? $clog2(NrRequesters) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NrRequesters-1:0]      req_valid_i,
  output logic [NrRequesters-1:0]      req_ready_o,
  input  logic [NrRequesters-1:0][63:0] req_addr_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [IdW-1:0]               rsp_id_o,
  output logic                         rsp_nonidem_o,
  output logic                         rsp_exec_o,
  output logic                         rsp_cache_o
);

  localparam int NrNi     = int'(CVA6Cfg.NrNonIdempotentRules);
  localparam int NrEx     = int'(CVA6Cfg.NrExecuteRegionRules);
  localparam int NrCa     = int'(CVA6Cfg.NrCachedRegionRules);
  localparam int MaxNiEx  = (NrNi > NrEx) ? NrNi : NrEx;
  localparam int MaxRules = (MaxNiEx > NrCa) ? MaxNiEx : NrCa;
  localparam int S        = (MaxRules + RulesPerCycle - 1) / RulesPerCycle;
  localparam int KW       = $clog2(2 * NrMaxRules + 1);
  localparam int RIW      = (NrMaxRules > 1) ? $clog2(NrMaxRules) : 1;
  localparam bit NoExec   = (NrEx == 0);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t          state;
  logic [IdW-1:0]  rr_ptr;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_nxt;
  logic [63:0]     addr_q;
  logic            acc_ni, acc_ex, acc_ca;
  logic            nxt_ni, nxt_ex, nxt_ca;
  logic            scan_done;
  logic            early;
  logic            gnt_found;
  logic [IdW-1:0]  gnt_idx;
  logic [IdW-1:0]  cidx;
  int              cand;
  int              j;
  logic [RIW-1:0]  ridx;

  // Upper bound is exclusive and evaluated on 65 bits so base+len cannot wrap.
  function automatic logic in_range(input logic [63:0] a, input logic [63:0] base,
                                    input logic [63:0] len);
    logic [64:0] top;
    top = {1'b0, base} + {1'b0, len};
    return (a >= base) && ({1'b0, a} < top);
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int o = 0; o < NrRequesters; o++) begin
      cand = (int'(rr_ptr) + o) % NrRequesters;
      cidx = IdW'(cand);
      if (!gnt_found && req_valid_i[cidx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cidx;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state == IDLE && !rst_i && gnt_found) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    nxt_ni = acc_ni;
    nxt_ex = acc_ex;
    nxt_ca = acc_ca;
    j      = 0;
    ridx   = '0;
    for (int r = 0; r < RulesPerCycle; r++) begin
      j    = int'(k) + r;
      ridx = RIW'(j);
      if (j < NrNi && in_range(addr_q, CVA6Cfg.NonIdempotentAddrBase[ridx],
                               CVA6Cfg.NonIdempotentLength[ridx])) nxt_ni = 1'b1;
      if (j < NrEx && in_range(addr_q, CVA6Cfg.ExecuteRegionAddrBase[ridx],
                               CVA6Cfg.ExecuteRegionLength[ridx])) nxt_ex = 1'b1;
      if (j < NrCa && in_range(addr_q, CVA6Cfg.CachedRegionAddrBase[ridx],
                               CVA6Cfg.CachedRegionLength[ridx])) nxt_ca = 1'b1;
    end
  end

  assign k_nxt     = k + KW'(RulesPerCycle);
  assign scan_done = (int'(k_nxt) >= MaxRules);

`ifdef PMA_CHECK_EARLY_EXIT_EN
  assign early = nxt_ni & (nxt_ex | NoExec) & nxt_ca;
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      k             <= '0;
      addr_q        <= '0;
      acc_ni        <= 1'b0;
      acc_ex        <= 1'b0;
      acc_ca        <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_id_o      <= '0;
      rsp_nonidem_o <= 1'b0;
      rsp_exec_o    <= 1'b0;
      rsp_cache_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            addr_q   <= req_addr_i[gnt_idx];
            rsp_id_o <= gnt_idx;
            rr_ptr   <= (gnt_idx == IdW'(NrRequesters - 1)) ? '0 : gnt_idx + IdW'(1);
            acc_ni   <= 1'b0;
            acc_ex   <= 1'b0;
            acc_ca   <= 1'b0;
            k        <= '0;
            if (S > 0) begin
              state <= SCAN;
            end else begin
              state         <= RESP;
              rsp_valid_o   <= 1'b1;
              rsp_nonidem_o <= 1'b0;
              rsp_exec_o    <= NoExec;
              rsp_cache_o   <= 1'b0;
            end
          end
        end
        SCAN: begin
          acc_ni <= nxt_ni;
          acc_ex <= nxt_ex;
          acc_ca <= nxt_ca;
          k      <= k_nxt;
          if (scan_done || early) begin
            state         <= RESP;
            rsp_valid_o   <= 1'b1;
            rsp_nonidem_o <= nxt_ni;
            rsp_exec_o    <= nxt_ex | NoExec;
            rsp_cache_o   <= nxt_ca;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state         <= IDLE;
            rsp_valid_o   <= 1'b0;
            rsp_nonidem_o <= 1'b0;
            rsp_exec_o    <= 1'b0;
            rsp_cache_o   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pma_seq_checker.sv
// Directed bench for pma_seq_checker: two requesters, two-rule configuration, one rule per cycle.
module tb_pma_seq_checker;
  import pma_seq_checker_pkg::*;

  function automatic cva6_cfg_t make_cfg();
    cva6_cfg_t c;
    c = '0;
    c.NrNonIdempotentRules     = 2;
    c.NonIdempotentAddrBase[0] = 64'h8000_0000;
    c.NonIdempotentLength[0]   = 64'h1000;
    c.NonIdempotentAddrBase[1] = 64'h0;
    c.NonIdempotentLength[1]   = 64'h1_0000;
    c.NrExecuteRegionRules     = 2;
    c.ExecuteRegionAddrBase[0] = 64'h8000_0000;
    c.ExecuteRegionLength[0]   = 64'h4000_0000;
    c.ExecuteRegionAddrBase[1] = 64'h1_0000;
    c.ExecuteRegionLength[1]   = 64'h1_0000;
    c.NrCachedRegionRules      = 1;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    return c;
  endfunction

  localparam cva6_cfg_t TestCfg = make_cfg();

`ifdef PMA_CHECK_EARLY_EXIT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][63:0] req_addr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [0:0]       rsp_id;
  logic             rsp_nonidem, rsp_exec, rsp_cache;

  int n_tests = 0;
  int n_fail  = 0;

  pma_seq_checker #(.CVA6Cfg(TestCfg), .NrRequesters(2), .RulesPerCycle(1)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_id_o      (rsp_id),
    .rsp_nonidem_o (rsp_nonidem),
    .rsp_exec_o    (rsp_exec),
    .rsp_cache_o   (rsp_cache)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [63:0] addr;
    logic        ni;
    logic        ex;
    logic        ca;
    int          lat_early;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns one tick after the handshake edge (cycle A+1 begins).
  task automatic grant(input int r, input logic [63:0] a, input string name);
    int n;
    req_addr[r]  = a;
    req_valid[r] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[r] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " grant"}, 64'(req_ready[r]), 64'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic collect(input string name, input int exp_id, input logic ni, input logic ex,
                         input logic ca, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    check({name, " valid"},   64'(rsp_valid),   64'd1);
    check({name, " latency"}, 64'(lat),         64'(exp_lat));
    check({name, " id"},      64'(rsp_id),      64'(exp_id));
    check({name, " nonidem"}, 64'(rsp_nonidem), 64'(ni));
    check({name, " exec"},    64'(rsp_exec),    64'(ex));
    check({name, " cache"},   64'(rsp_cache),   64'(ca));
    @(posedge clk); #1;
  endtask

  initial begin
    int gq[$];
    int iq[$];
    int nrsp;
    logic both;

    vecs[0]  = '{0, 64'h8000_2000, 1'b0, 1'b1, 1'b1, 3};
    vecs[1]  = '{1, 64'h0000_FFFF, 1'b1, 1'b0, 1'b0, 3};
    vecs[2]  = '{0, 64'h0001_0000, 1'b0, 1'b1, 1'b0, 3};
    vecs[3]  = '{1, 64'hC000_0000, 1'b0, 1'b0, 1'b0, 3};
    vecs[4]  = '{0, 64'h8000_0010, 1'b1, 1'b1, 1'b1, 2};
    vecs[5]  = '{1, 64'h8000_0FFF, 1'b1, 1'b1, 1'b1, 2};
    vecs[6]  = '{0, 64'h8000_1000, 1'b0, 1'b1, 1'b1, 3};
    vecs[7]  = '{1, 64'hBFFF_FFFF, 1'b0, 1'b1, 1'b1, 3};
    vecs[8]  = '{0, 64'h0001_FFFF, 1'b0, 1'b1, 1'b0, 3};
    vecs[9]  = '{1, 64'h0002_0000, 1'b0, 1'b0, 1'b0, 3};
    vecs[10] = '{0, 64'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 3};

    rst       = 1'b1;
    req_valid = 2'b11;
    req_addr  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 64'(req_ready),   64'd0);
    check("reset rsp_valid", 64'(rsp_valid),   64'd0);
    check("reset rsp_id",    64'(rsp_id),      64'd0);
    check("reset nonidem",   64'(rsp_nonidem), 64'd0);
    check("reset exec",      64'(rsp_exec),    64'd0);
    check("reset cache",     64'(rsp_cache),   64'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 2'b00;

    for (int i = 0; i < 11; i++) begin
      grant(vecs[i].req, vecs[i].addr, $sformatf("vec%0d", i));
      collect($sformatf("vec%0d", i), vecs[i].req, vecs[i].ni, vecs[i].ex, vecs[i].ca,
              EarlyEn ? vecs[i].lat_early : 3);
    end

    // Both requesters continuously valid: alternate from requester 0.
    do_reset();
    req_addr[0] = 64'h8000_2000;
    req_addr[1] = 64'h0000_FFFF;
    req_valid   = 2'b11;
    nrsp = 0;
    both = 1'b0;
    for (int c = 0; c < 80 && nrsp < 4; c++) begin
      @(negedge clk);
      if (req_ready == 2'b11) both = 1'b1;
      if (req_ready == 2'b01) gq.push_back(0);
      if (req_ready == 2'b10) gq.push_back(1);
      if (rsp_valid) begin
        nrsp++;
        iq.push_back(int'(rsp_id));
        if (rsp_id == 1'b0) check("rr nonidem", 64'({rsp_nonidem, rsp_exec, rsp_cache}), 64'b011);
        else                check("rr nonidem", 64'({rsp_nonidem, rsp_exec, rsp_cache}), 64'b100);
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("rr never both", 64'(both), 64'd0);
    check("rr responses",  64'(nrsp), 64'd4);
    check("rr grants",     64'(gq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) check($sformatf("rr grant%0d", i), 64'(gq[i]), 64'(i % 2));
      if (i < iq.size()) check($sformatf("rr id%0d", i),    64'(iq[i]), 64'(i % 2));
    end
    repeat (2) @(posedge clk); #1;

    // Back-pressure on the response with a competing requester waiting.
    rsp_ready = 1'b0;
    grant(0, 64'h8000_0010, "hold");
    req_addr[1]  = 64'h0;
    req_valid[1] = 1'b1;
    nrsp = 0;
    while (!rsp_valid && nrsp < 20) begin
      @(negedge clk);
      nrsp++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold valid",     64'(rsp_valid), 64'd1);
      check("hold outputs",   64'({rsp_id, rsp_nonidem, rsp_exec, rsp_cache}), 64'b0111);
      check("hold req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    check("hold last valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    check("hold consumed", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;

    // Reset during the first SCAN cycle drops the query and restarts the pointer.
    do_reset();
    grant(0, 64'h8000_2000, "rst scan");
    rst = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    req_addr[0] = 64'hC000_0000;
    req_addr[1] = 64'h0000_FFFF;
    req_valid   = 2'b11;
    @(negedge clk);
    check("rst scan valid",     64'(rsp_valid), 64'd0);
    check("rst scan outputs",   64'({rsp_id, rsp_nonidem, rsp_exec, rsp_cache}), 64'd0);
    check("rst scan req_ready", 64'(req_ready), 64'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    collect("rst scan next", 0, 1'b0, 1'b0, 1'b0, 3);

    // Reset while a response is held.
    rsp_ready = 1'b0;
    grant(1, 64'h0000_FFFF, "rst resp");
    nrsp = 0;
    while (!rsp_valid && nrsp < 20) begin
      @(negedge clk);
      nrsp++;
    end
    check("rst resp reached", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst resp outputs", 64'({rsp_valid, rsp_id, rsp_nonidem, rsp_exec, rsp_cache}), 64'd0);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
